// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: writes mepc/mcause/mstatus on trap entry, mstatus on mret,
// then issues a one-cycle fetch redirect. Stalls the pipeline while a sequence is in flight.
module trap_ctrl #(
  parameter bit          VECTORED_EN = 1'b1,
  parameter int unsigned TIMER_CAUSE = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  input  logic        ex_csr_we_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mip_i,
  output logic        ctrl_we_o,
  output logic [11:0] ctrl_waddr_o,
  output logic [31:0] ctrl_wdata_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o
);

  typedef enum logic [2:0] {
    StIdle, StTMepc, StTMcause, StTMstatus, StRMstatus, StJump
  } state_e;

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
  localparam logic [31:0] IrqCause    = {1'b1, 31'(TIMER_CAUSE)};

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        mret_q, mret_d;

  logic        irq, exc, accept;
  logic [31:0] base, trap_target, ms_trap, ms_mret;

  assign irq    = mstatus_i[3] & mie_i[TIMER_CAUSE] & mip_i[TIMER_CAUSE];
  assign exc    = illegal_i | ecall_i | ebreak_i;
  assign accept = inst_valid_i & (exc | mret_i | irq);

  assign base = {mtvec_i[31:2], 2'b00};
  // Only interrupts are vectored; exceptions always land on the base address.
  assign trap_target = (VECTORED_EN && mtvec_i[1:0] == 2'b01 && cause_q[31]) ?
                       base + {cause_q[29:0], 2'b00} : base;

  always_comb begin
    ms_trap        = mstatus_i;
    ms_trap[12:11] = 2'b11;
    ms_trap[7]     = mstatus_i[3];
    ms_trap[3]     = 1'b0;
    ms_mret        = mstatus_i;
    ms_mret[3]     = mstatus_i[7];
    ms_mret[7]     = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    mret_d       = mret_q;
    ctrl_we_o    = 1'b0;
    ctrl_waddr_o = 12'h000;
    ctrl_wdata_o = 32'h0;
    stall_o      = 1'b0;
    flush_o      = 1'b0;
    jump_o       = 1'b0;
    jump_addr_o  = 32'h0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          stall_o = 1'b1;
          flush_o = 1'b1;
          if (exc || !mret_i) begin
            epc_d   = pc_i;
            mret_d  = 1'b0;
            state_d = StTMepc;
            if (illegal_i)     cause_d = 32'd2;
            else if (ecall_i)  cause_d = 32'd11;
            else if (ebreak_i) cause_d = 32'd3;
            else               cause_d = IrqCause;
          end else begin
            mret_d  = 1'b1;
            state_d = StRMstatus;
          end
        end
      end
      // Write states hold while EX owns the CSR port; csr_reg drops our write then.
      StTMepc: begin
        stall_o      = 1'b1;
        ctrl_we_o    = 1'b1;
        ctrl_waddr_o = AddrMepc;
        ctrl_wdata_o = epc_q;
        if (!ex_csr_we_i) state_d = StTMcause;
      end
      StTMcause: begin
        stall_o      = 1'b1;
        ctrl_we_o    = 1'b1;
        ctrl_waddr_o = AddrMcause;
        ctrl_wdata_o = cause_q;
        if (!ex_csr_we_i) state_d = StTMstatus;
      end
      StTMstatus: begin
        stall_o      = 1'b1;
        ctrl_we_o    = 1'b1;
        ctrl_waddr_o = AddrMstatus;
        ctrl_wdata_o = ms_trap;
        if (!ex_csr_we_i) state_d = StJump;
      end
      StRMstatus: begin
        stall_o      = 1'b1;
        ctrl_we_o    = 1'b1;
        ctrl_waddr_o = AddrMstatus;
        ctrl_wdata_o = ms_mret;
        if (!ex_csr_we_i) state_d = StJump;
      end
      StJump: begin
        stall_o     = 1'b1;
        flush_o     = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = mret_q ? mepc_i : trap_target;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      epc_q   <= 32'h0;
      cause_q <= 32'h0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, hand sequences for CSR-port
// collisions and mid-sequence reset, then random traffic against a transaction-level model.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        inst_valid_i, ecall_i, ebreak_i, illegal_i, mret_i, ex_csr_we_i;
  logic [31:0] pc_i, mstatus_i, mepc_i, mtvec_i, mie_i, mip_i;
  logic        ctrl_we_o, stall_o, flush_o, jump_o;
  logic [11:0] ctrl_waddr_o;
  logic [31:0] ctrl_wdata_o, jump_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  trap_ctrl #(
    .VECTORED_EN (1'b1),
    .TIMER_CAUSE (7)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .inst_valid_i (inst_valid_i),
    .pc_i         (pc_i),
    .ecall_i      (ecall_i),
    .ebreak_i     (ebreak_i),
    .illegal_i    (illegal_i),
    .mret_i       (mret_i),
    .ex_csr_we_i  (ex_csr_we_i),
    .mstatus_i    (mstatus_i),
    .mepc_i       (mepc_i),
    .mtvec_i      (mtvec_i),
    .mie_i        (mie_i),
    .mip_i        (mip_i),
    .ctrl_we_o    (ctrl_we_o),
    .ctrl_waddr_o (ctrl_waddr_o),
    .ctrl_wdata_o (ctrl_wdata_o),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .jump_o       (jump_o),
    .jump_addr_o  (jump_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  trap;  // {illegal, ecall, ebreak, mret}
    logic [31:0] ms, mepc, mtvec, mie, mip;
    logic [1:0]  nw;
    logic [11:0] a0; logic [31:0] d0;
    logic [11:0] a1; logic [31:0] d1;
    logic [11:0] a2; logic [31:0] d2;
    logic [31:0] ja;
  } vec_t;

  // Packed layout: {we, addr, wdata, stall, flush, jump, jaddr}; jump is bit 32.
  function automatic logic [79:0] pk(logic we, logic [11:0] a, logic [31:0] d,
                                     logic st, logic fl, logic jp, logic [31:0] ja);
    return {we, a, d, st, fl, jp, ja};
  endfunction

  task automatic check(input string name, input logic [79:0] exp, input logic full);
    logic [79:0] act;
    logic [79:0] m;
    act = {ctrl_we_o, ctrl_waddr_o, ctrl_wdata_o, stall_o, flush_o, jump_o, jump_addr_o};
    m   = (full || exp[32]) ? {80{1'b1}} : {{48{1'b1}}, 32'h0};
    n_tests++;
    if ((act & m) !== (exp & m)) begin
      n_fail++;
      $display("FAIL %s: got {we,addr,wdata,stall,flush,jump,jaddr}=%h, expected %h",
               name, act & m, exp & m);
    end
  endtask

  task automatic step(input string name, input logic [79:0] exp);
    @(negedge clk_i);
    check(name, exp, 1'b0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_traps();
    inst_valid_i = 1'b0;
    {illegal_i, ecall_i, ebreak_i, mret_i} = 4'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [11:0] wa[3];
    logic [31:0] wd[3];
    wa = '{v.a0, v.a1, v.a2};
    wd = '{v.d0, v.d1, v.d2};
    pc_i = v.pc; mstatus_i = v.ms; mepc_i = v.mepc; mtvec_i = v.mtvec;
    mie_i = v.mie; mip_i = v.mip;
    {illegal_i, ecall_i, ebreak_i, mret_i} = v.trap;
    inst_valid_i = 1'b1;
    step({tag, " accept"}, pk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
    clear_traps();
    for (int k = 0; k < int'(v.nw); k++)
      step($sformatf("%s write%0d", tag, k), pk(1'b1, wa[k], wd[k], 1'b1, 1'b0, 1'b0, 32'h0));
    step({tag, " jump"}, pk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b1, v.ja));
    step({tag, " idle"}, pk(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
  endtask

  vec_t vecs[6];
  vec_t v;

  // Random-phase reference model: queue of pending CSR writes, then one redirect.
  logic [43:0] wq[$];
  logic        jp_pend;
  logic [31:0] jtgt, cause, base, msw;
  logic        irq, req, busy;
  logic [79:0] exp;

  initial begin
    rst_ni = 1'b0;
    clear_traps();
    ex_csr_we_i = 1'b0;
    pc_i = '0; mstatus_i = '0; mepc_i = '0; mtvec_i = '0; mie_i = '0; mip_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset", 80'h0, 1'b1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    vecs[0] = '{32'h100, 4'b0100, 32'h8, 32'h0, 32'h50, 32'h0, 32'h0, 2'd3,
                12'h341, 32'h100, 12'h342, 32'hB, 12'h300, 32'h1880, 32'h50};
    vecs[1] = '{32'h200, 4'b0000, 32'h8, 32'h0, 32'h51, 32'h80, 32'h80, 2'd3,
                12'h341, 32'h200, 12'h342, 32'h8000_0007, 12'h300, 32'h1880, 32'h6C};
    vecs[2] = '{32'h0, 4'b0001, 32'h1880, 32'h104, 32'h50, 32'h0, 32'h0, 2'd1,
                12'h300, 32'h1888, 12'h0, 32'h0, 12'h0, 32'h0, 32'h104};
    vecs[3] = '{32'h300, 4'b1000, 32'h1888, 32'h0, 32'h51, 32'h0, 32'h0, 2'd3,
                12'h341, 32'h300, 12'h342, 32'h2, 12'h300, 32'h1880, 32'h50};
    vecs[4] = '{32'h44, 4'b0011, 32'h0, 32'h0, 32'h104, 32'h0, 32'h0, 2'd3,
                12'h341, 32'h44, 12'h342, 32'h3, 12'h300, 32'h1800, 32'h104};
    vecs[5] = '{32'h0, 4'b0001, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0, 2'd1,
                12'h300, 32'h80, 12'h0, 32'h0, 12'h0, 32'h0, 32'h200};
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    mie_i = '0; mip_i = '0;

    // ecall and timer irq together: exception wins, irq waits until MIE is back.
    v = '{32'h400, 4'b0100, 32'h8, 32'h0, 32'h51, 32'h80, 32'h80, 2'd3,
          12'h341, 32'h400, 12'h342, 32'hB, 12'h300, 32'h1880, 32'h50};
    run_vec(v, "ecall+irq");
    mstatus_i = 32'h1880; pc_i = 32'h404; inst_valid_i = 1'b1;
    step("irq masked", pk(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    v = '{32'h404, 4'b0001, 32'h1880, 32'h404, 32'h51, 32'h80, 32'h80, 2'd1,
          12'h300, 32'h1888, 12'h0, 32'h0, 12'h0, 32'h0, 32'h404};
    run_vec(v, "mret back");
    v = '{32'h404, 4'b0000, 32'h1888, 32'h404, 32'h51, 32'h80, 32'h80, 2'd3,
          12'h341, 32'h404, 12'h342, 32'h8000_0007, 12'h300, 32'h1880, 32'h6C};
    run_vec(v, "irq later");
    mie_i = '0; mip_i = '0;

    // EX owns the CSR port for two cycles during the mcause write.
    pc_i = 32'h100; mstatus_i = 32'h8; mtvec_i = 32'h50; ecall_i = 1'b1; inst_valid_i = 1'b1;
    step("col accept", pk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
    clear_traps();
    step("col mepc", pk(1'b1, 12'h341, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0));
    ex_csr_we_i = 1'b1;
    step("col mcause0", pk(1'b1, 12'h342, 32'hB, 1'b1, 1'b0, 1'b0, 32'h0));
    step("col mcause1", pk(1'b1, 12'h342, 32'hB, 1'b1, 1'b0, 1'b0, 32'h0));
    ex_csr_we_i = 1'b0;
    step("col mcause2", pk(1'b1, 12'h342, 32'hB, 1'b1, 1'b0, 1'b0, 32'h0));
    step("col mstatus", pk(1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 1'b0, 32'h0));
    step("col jump T+6", pk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h50));

    // Reset asserted in the middle of the mcause write.
    ecall_i = 1'b1; inst_valid_i = 1'b1;
    step("rst accept", pk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
    clear_traps();
    step("rst mepc", pk(1'b1, 12'h341, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0));
    @(negedge clk_i);
    check("rst mcause", pk(1'b1, 12'h342, 32'hB, 1'b1, 1'b0, 1'b0, 32'h0), 1'b0);
    #2 rst_ni = 1'b0;
    #1 check("rst immediate", 80'h0, 1'b1);
    @(posedge clk_i); #1;
    check("rst held", 80'h0, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 4; i++) step($sformatf("rst idle%0d", i), 80'h0);

    // Random traffic; CSR/pc inputs only change while the model is idle.
    jp_pend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      busy = (wq.size() != 0) || jp_pend;
      if (!busy) begin
        pc_i = $urandom; mstatus_i = $urandom; mepc_i = $urandom; mtvec_i = $urandom;
        mie_i = $urandom; mip_i = $urandom;
      end
      inst_valid_i = ($urandom_range(0, 3) != 0);
      illegal_i    = ($urandom_range(0, 9) == 0);
      ecall_i      = ($urandom_range(0, 9) == 0);
      ebreak_i     = ($urandom_range(0, 9) == 0);
      mret_i       = ($urandom_range(0, 9) == 0);
      ex_csr_we_i  = ($urandom_range(0, 2) == 0);
      @(negedge clk_i);
      if (wq.size() != 0) begin
        exp = pk(1'b1, wq[0][43:32], wq[0][31:0], 1'b1, 1'b0, 1'b0, 32'h0);
        if (!ex_csr_we_i) void'(wq.pop_front());
      end else if (jp_pend) begin
        exp = pk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b1, jtgt);
        jp_pend = 1'b0;
      end else begin
        irq = mstatus_i[3] & mie_i[7] & mip_i[7];
        req = inst_valid_i & (illegal_i | ecall_i | ebreak_i | mret_i | irq);
        exp = pk(1'b0, 12'h0, 32'h0, req, req, 1'b0, 32'h0);
        if (req) begin
          jp_pend = 1'b1;
          if (!illegal_i && !ecall_i && !ebreak_i && mret_i) begin
            msw = (mstatus_i & ~32'h88) | 32'h80 | ((mstatus_i >> 4) & 32'h8);
            wq.push_back({12'h300, msw});
            jtgt = mepc_i;
          end else begin
            cause = illegal_i ? 32'd2 : ecall_i ? 32'd11 : ebreak_i ? 32'd3 : 32'h8000_0007;
            msw   = (mstatus_i & ~32'h1888) | 32'h1800 | ((mstatus_i & 32'h8) << 4);
            wq.push_back({12'h341, pc_i});
            wq.push_back({12'h342, cause});
            wq.push_back({12'h300, msw});
            base = mtvec_i & ~32'h3;
            jtgt = (cause[31] && mtvec_i[1:0] == 2'b01) ? base + 4 * (cause & 32'h7FFF_FFFF)
                                                         : base;
          end
        end
      end
      check($sformatf("rand%0d", n), exp, 1'b0);
      @(posedge clk_i); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
